priv_1_12_trap_sequencer: RTL and testbench

- Sits between the pipeline hazard/exception sources and the privilege CSR file.
- Latches one trap event per episode: a synchronous exception, a pending interrupt, or an mret.
- Waits for the pipeline to drain, then issues a single-cycle CSR update burst (mcause/mepc/mtval/mstatus/privilege).
- Follows with a single-cycle PC redirect to the trap vector or mepc.

---
 rtl/machine_mode_types_1_12_pkg.sv | 42 ++++
 rtl/priv_1_12_irq_prio.sv | 27 ++
 rtl/priv_1_12_trap_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_priv_1_12_trap_sequencer.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/machine_mode_types_1_12_pkg.sv
// Shared types and constants for the machine-mode trap sequencer: FSM states,
// privilege encodings, cause codes and the fixed interrupt priority order.
package machine_mode_types_1_12_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_CLEAR,
    ST_COMMIT,
    ST_REDIRECT
  } trap_seq_state_t;

  typedef enum logic [1:0] {
    PRIV_U = 2'b00,
    PRIV_S = 2'b01,
    PRIV_M = 2'b11
  } priv_level_t;

  typedef enum logic [1:0] {
    EV_EXC,
    EV_IRQ,
    EV_MRET
  } trap_kind_t;

  localparam logic [3:0] IRQ_SSI = 4'd1;
  localparam logic [3:0] IRQ_MSI = 4'd3;
  localparam logic [3:0] IRQ_STI = 4'd5;
  localparam logic [3:0] IRQ_MTI = 4'd7;
  localparam logic [3:0] IRQ_SEI = 4'd9;
  localparam logic [3:0] IRQ_MEI = 4'd11;

  localparam logic [3:0] EXC_INSTR_MISALIGNED = 4'd0;
  localparam logic [3:0] EXC_ILLEGAL_INSTR    = 4'd2;
  localparam logic [3:0] EXC_BREAKPOINT       = 4'd3;
  localparam logic [3:0] EXC_ECALL_U          = 4'd8;
  localparam logic [3:0] EXC_ECALL_M          = 4'd11;

  // Highest priority first.
  localparam int IRQ_PRIO_DEPTH = 6;
  localparam logic [3:0] IRQ_PRIO_ORDER [IRQ_PRIO_DEPTH] =
    '{IRQ_MEI, IRQ_MSI, IRQ_MTI, IRQ_SEI, IRQ_SSI, IRQ_STI};

endpackage

// File: rtl/priv_1_12_irq_prio.sv
// Combinational interrupt priority encoder over mip & mie. Standard interrupts
// win in architectural order; any other pending line falls back to highest index.
module priv_1_12_irq_prio
  import machine_mode_types_1_12_pkg::*;
#(
  parameter int NUM_IRQ = 12
) (
  input  logic [NUM_IRQ-1:0] i_pending,
  output logic               o_valid,
  output logic [3:0]         o_code
);

  always_comb begin
    o_valid = |i_pending;
    o_code  = 4'd0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (i < 16 && i_pending[i]) o_code = 4'(i);
    end
    // Walk from lowest to highest priority so the strongest pending one sticks.
    for (int k = IRQ_PRIO_DEPTH - 1; k >= 0; k--) begin
      if (int'(IRQ_PRIO_ORDER[k]) < NUM_IRQ && i_pending[IRQ_PRIO_ORDER[k]]) begin
        o_code = IRQ_PRIO_ORDER[k];
      end
    end
  end

endmodule

// File: rtl/priv_1_12_trap_sequencer.sv
// Latches one exception/interrupt/mret per episode, waits for the pipeline to
// drain, then strobes the CSR update and the PC redirect. Optional: PRIV_VECTORED_TRAP_EN.
module priv_1_12_trap_sequencer
  import machine_mode_types_1_12_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_IRQ = 12
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_exc_valid,
  input  logic [3:0]         i_exc_code,
  input  logic [XLEN-1:0]    i_exc_tval,
  input  logic [XLEN-1:0]    i_epc,
  input  logic [NUM_IRQ-1:0] i_mip,
  input  logic [NUM_IRQ-1:0] i_mie,
  input  logic               i_mstatus_mie,
  input  logic               i_mstatus_mpie,
  input  logic [1:0]         i_mstatus_mpp,
  input  logic [1:0]         i_curr_priv,
  input  logic [XLEN-1:0]    i_mtvec,
  input  logic [XLEN-1:0]    i_mepc_in,
  input  logic               i_mret,
  input  logic               i_pipe_clear,
  output logic               o_busy,
  output logic               o_intr,
  output logic               o_inject_csr,
  output logic [XLEN-1:0]    o_next_mcause,
  output logic [XLEN-1:0]    o_next_mepc,
  output logic [XLEN-1:0]    o_next_mtval,
  output logic               o_next_mie_bit,
  output logic               o_next_mpie,
  output logic [1:0]         o_next_mpp,
  output logic [1:0]         o_next_priv,
  output logic               o_insert_pc,
  output logic [XLEN-1:0]    o_priv_pc
);

  trap_seq_state_t r_state;
  trap_kind_t      r_kind;
  logic            r_busy;
  logic            r_intr;
  logic            r_inject;
  logic            r_insert;
  logic [3:0]      r_code;
  logic [XLEN-1:0] r_epc;
  logic [XLEN-1:0] r_tval;
  logic [XLEN-3:0] r_mepc_in;
  logic            r_mstatus_mie;
  logic            r_mstatus_mpie;
  logic [1:0]      r_mstatus_mpp;
  logic [1:0]      r_curr_priv;
  logic [XLEN-1:0] r_mcause;
  logic [XLEN-1:0] r_mepc;
  logic [XLEN-1:0] r_mtval;
  logic            r_next_mie_bit;
  logic            r_next_mpie;
  logic [1:0]      r_next_mpp;
  logic [1:0]      r_next_priv;
  logic [XLEN-1:0] r_priv_pc;

  logic [NUM_IRQ-1:0] w_pending;
  logic               w_irq_valid;
  logic [3:0]         w_irq_code;
  logic               w_irq_take;
  logic               w_event;
  logic [XLEN-1:0]    w_trap_base;
  logic [XLEN-1:0]    w_trap_pc;

  assign w_pending = i_mip & i_mie;

  priv_1_12_irq_prio #(
    .NUM_IRQ (NUM_IRQ)
  ) u_irq_prio (
    .i_pending (w_pending),
    .o_valid   (w_irq_valid),
    .o_code    (w_irq_code)
  );

  // In M-mode interrupts need mstatus.MIE; lower modes are always interruptible.
  assign w_irq_take  = w_irq_valid && ((i_curr_priv != PRIV_M) || i_mstatus_mie);
  assign w_event     = i_exc_valid || w_irq_take || i_mret;
  assign w_trap_base = {i_mtvec[XLEN-1:2], 2'b00};

`ifdef PRIV_VECTORED_TRAP_EN
  always_comb begin
    w_trap_pc = w_trap_base;
    if (i_mtvec[1:0] == 2'b01 && r_kind == EV_IRQ) begin
      w_trap_pc = w_trap_base + XLEN'({r_code, 2'b00});
    end
  end
`else
  logic w_unused_mtvec_mode;
  assign w_unused_mtvec_mode = ^i_mtvec[1:0];
  assign w_trap_pc = w_trap_base;
`endif

  // Strobes and next_* values are registered, so each appears the cycle after
  // the FSM sits in the state that decides it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= ST_IDLE;
      r_kind         <= EV_EXC;
      r_busy         <= 1'b0;
      r_intr         <= 1'b0;
      r_inject       <= 1'b0;
      r_insert       <= 1'b0;
      r_code         <= '0;
      r_epc          <= '0;
      r_tval         <= '0;
      r_mepc_in      <= '0;
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mstatus_mpp  <= '0;
      r_curr_priv    <= '0;
      r_mcause       <= '0;
      r_mepc         <= '0;
      r_mtval        <= '0;
      r_next_mie_bit <= 1'b0;
      r_next_mpie    <= 1'b0;
      r_next_mpp     <= '0;
      r_next_priv    <= '0;
      r_priv_pc      <= '0;
    end else begin
      r_inject <= 1'b0;
      r_insert <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_event) begin
            r_state        <= ST_WAIT_CLEAR;
            r_busy         <= 1'b1;
            r_epc          <= i_epc;
            r_mepc_in      <= i_mepc_in[XLEN-1:2];
            r_mstatus_mie  <= i_mstatus_mie;
            r_mstatus_mpie <= i_mstatus_mpie;
            r_mstatus_mpp  <= i_mstatus_mpp;
            r_curr_priv    <= i_curr_priv;
            if (i_exc_valid) begin
              r_kind <= EV_EXC;
              r_intr <= 1'b0;
              r_code <= i_exc_code;
              r_tval <= i_exc_tval;
            end else if (w_irq_take) begin
              r_kind <= EV_IRQ;
              r_intr <= 1'b1;
              r_code <= w_irq_code;
              r_tval <= '0;
            end else begin
              r_kind <= EV_MRET;
              r_intr <= 1'b0;
              r_code <= '0;
              r_tval <= '0;
            end
          end
        end
        ST_WAIT_CLEAR: begin
          if (i_pipe_clear) r_state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          r_state  <= ST_REDIRECT;
          r_inject <= 1'b1;
          if (r_kind == EV_MRET) begin
            r_next_mie_bit <= r_mstatus_mpie;
            r_next_mpie    <= 1'b1;
            r_next_mpp     <= PRIV_U;
            r_next_priv    <= r_mstatus_mpp;
          end else begin
            r_mcause       <= {r_intr, {(XLEN-5){1'b0}}, r_code};
            r_mepc         <= r_epc;
            r_mtval        <= r_tval;
            r_next_mie_bit <= 1'b0;
            r_next_mpie    <= r_mstatus_mie;
            r_next_mpp     <= r_curr_priv;
            r_next_priv    <= PRIV_M;
          end
        end
        ST_REDIRECT: begin
          r_state   <= ST_IDLE;
          r_busy    <= 1'b0;
          r_insert  <= 1'b1;
          r_priv_pc <= (r_kind == EV_MRET) ? {r_mepc_in, 2'b00} : w_trap_pc;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy         = r_busy;
  assign o_intr         = r_intr;
  assign o_inject_csr   = r_inject;
  assign o_next_mcause  = r_mcause;
  assign o_next_mepc    = r_mepc;
  assign o_next_mtval   = r_mtval;
  assign o_next_mie_bit = r_next_mie_bit;
  assign o_next_mpie    = r_next_mpie;
  assign o_next_mpp     = r_next_mpp;
  assign o_next_priv    = r_next_priv;
  assign o_insert_pc    = r_insert;
  assign o_priv_pc      = r_priv_pc;

endmodule

// File: tb/tb_priv_1_12_trap_sequencer.sv
// Self-checking bench for priv_1_12_trap_sequencer: directed vector table,
// randomized episodes against a reference model, reset-in-flight sequence.
module tb_priv_1_12_trap_sequencer;

  localparam int XLEN    = 32;
  localparam int NUM_IRQ = 12;

`ifdef PRIV_VECTORED_TRAP_EN
  localparam logic [31:0] MEI_PC = 32'h0000_802C;
  localparam logic [31:0] SSI_PC = 32'h0000_9004;
`else
  localparam logic [31:0] MEI_PC = 32'h0000_8000;
  localparam logic [31:0] SSI_PC = 32'h0000_9000;
`endif

  typedef struct packed {
    logic        exc_valid;
    logic [3:0]  exc_code;
    logic [31:0] exc_tval;
    logic [31:0] epc;
    logic [11:0] mip;
    logic [11:0] mie;
    logic        mstatus_mie;
    logic        mstatus_mpie;
    logic [1:0]  mstatus_mpp;
    logic [1:0]  curr_priv;
    logic [31:0] mtvec;
    logic [31:0] mepc_in;
    logic        mret;
  } stim_t;

  typedef struct packed {
    logic        taken;
    logic        intr;
    logic [31:0] mcause;
    logic [31:0] mepc;
    logic [31:0] mtval;
    logic        mie_bit;
    logic        mpie;
    logic [1:0]  mpp;
    logic [1:0]  priv;
    logic [31:0] pc;
  } exp_t;

  typedef struct {
    string name;
    stim_t s;
    exp_t  e;
    int    clearDelay;
  } vec_t;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic              i_exc_valid = 1'b0;
  logic [3:0]        i_exc_code = '0;
  logic [XLEN-1:0]   i_exc_tval = '0;
  logic [XLEN-1:0]   i_epc = '0;
  logic [NUM_IRQ-1:0] i_mip = '0;
  logic [NUM_IRQ-1:0] i_mie = '0;
  logic              i_mstatus_mie = 1'b0;
  logic              i_mstatus_mpie = 1'b0;
  logic [1:0]        i_mstatus_mpp = '0;
  logic [1:0]        i_curr_priv = '0;
  logic [XLEN-1:0]   i_mtvec = '0;
  logic [XLEN-1:0]   i_mepc_in = '0;
  logic              i_mret = 1'b0;
  logic              i_pipe_clear = 1'b0;
  logic              o_busy;
  logic              o_intr;
  logic              o_inject_csr;
  logic [XLEN-1:0]   o_next_mcause;
  logic [XLEN-1:0]   o_next_mepc;
  logic [XLEN-1:0]   o_next_mtval;
  logic              o_next_mie_bit;
  logic              o_next_mpie;
  logic [1:0]        o_next_mpp;
  logic [1:0]        o_next_priv;
  logic              o_insert_pc;
  logic [XLEN-1:0]   o_priv_pc;

  int checks = 0;
  int errors = 0;
  logic [31:0] heldCause = '0;
  logic [31:0] heldEpc = '0;
  logic [31:0] heldTval = '0;
  vec_t vecs[8];
  int numVecs = 0;

  always #5 i_clk = ~i_clk;

  priv_1_12_trap_sequencer #(
    .XLEN    (XLEN),
    .NUM_IRQ (NUM_IRQ)
  ) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_exc_valid    (i_exc_valid),
    .i_exc_code     (i_exc_code),
    .i_exc_tval     (i_exc_tval),
    .i_epc          (i_epc),
    .i_mip          (i_mip),
    .i_mie          (i_mie),
    .i_mstatus_mie  (i_mstatus_mie),
    .i_mstatus_mpie (i_mstatus_mpie),
    .i_mstatus_mpp  (i_mstatus_mpp),
    .i_curr_priv    (i_curr_priv),
    .i_mtvec        (i_mtvec),
    .i_mepc_in      (i_mepc_in),
    .i_mret         (i_mret),
    .i_pipe_clear   (i_pipe_clear),
    .o_busy         (o_busy),
    .o_intr         (o_intr),
    .o_inject_csr   (o_inject_csr),
    .o_next_mcause  (o_next_mcause),
    .o_next_mepc    (o_next_mepc),
    .o_next_mtval   (o_next_mtval),
    .o_next_mie_bit (o_next_mie_bit),
    .o_next_mpie    (o_next_mpie),
    .o_next_mpp     (o_next_mpp),
    .o_next_priv    (o_next_priv),
    .o_insert_pc    (o_insert_pc),
    .o_priv_pc      (o_priv_pc)
  );

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input stim_t s, input logic pipeClear);
    i_exc_valid    = s.exc_valid;
    i_exc_code     = s.exc_code;
    i_exc_tval     = s.exc_tval;
    i_epc          = s.epc;
    i_mip          = s.mip;
    i_mie          = s.mie;
    i_mstatus_mie  = s.mstatus_mie;
    i_mstatus_mpie = s.mstatus_mpie;
    i_mstatus_mpp  = s.mstatus_mpp;
    i_curr_priv    = s.curr_priv;
    i_mtvec        = s.mtvec;
    i_mepc_in      = s.mepc_in;
    i_mret         = s.mret;
    i_pipe_clear   = pipeClear;
  endtask

  task automatic addVec(input string name, input stim_t s, input exp_t e, input int clearDelay);
    vecs[numVecs].name       = name;
    vecs[numVecs].s          = s;
    vecs[numVecs].e          = e;
    vecs[numVecs].clearDelay = clearDelay;
    numVecs++;
  endtask

  // Reference: decide the winning event from the architectural rules and
  // compute the resulting CSR image and redirect target directly.
  function automatic exp_t modelEpisode(input stim_t s, input logic [31:0] hc,
                                        input logic [31:0] he, input logic [31:0] ht);
    exp_t e;
    logic [11:0] pend;
    int order[6];
    int irqCode;
    int trapCode;
    bit irqOk;
    order = '{11, 3, 7, 9, 1, 5};
    e = '0;
    pend = s.mip & s.mie;
    irqCode = -1;
    for (int k = 0; k < 6; k++) begin
      if (irqCode < 0 && pend[order[k]]) irqCode = order[k];
    end
    irqOk = (irqCode >= 0) && (s.curr_priv != 2'b11 || s.mstatus_mie);
    if (s.exc_valid || irqOk) begin
      e.taken   = 1'b1;
      e.intr    = !s.exc_valid;
      trapCode  = s.exc_valid ? int'(s.exc_code) : irqCode;
      e.mcause  = (e.intr ? 32'h8000_0000 : 32'h0) + 32'(trapCode);
      e.mepc    = s.epc;
      e.mtval   = s.exc_valid ? s.exc_tval : 32'h0;
      e.mie_bit = 1'b0;
      e.mpie    = s.mstatus_mie;
      e.mpp     = s.curr_priv;
      e.priv    = 2'b11;
      e.pc      = (s.mtvec / 4) * 4;
`ifdef PRIV_VECTORED_TRAP_EN
      if (e.intr && (s.mtvec % 4) == 1) e.pc = e.pc + 32'(4 * trapCode);
`endif
    end else if (s.mret) begin
      e.taken   = 1'b1;
      e.intr    = 1'b0;
      e.mcause  = hc;
      e.mepc    = he;
      e.mtval   = ht;
      e.mie_bit = s.mstatus_mpie;
      e.mpie    = 1'b1;
      e.mpp     = 2'b00;
      e.priv    = s.mstatus_mpp;
      e.pc      = (s.mepc_in / 4) * 4;
    end
    return e;
  endfunction

  // One full episode: event sampled at edge t, latched inputs scrambled right
  // after, new events thrown at the FSM while it waits, then strobe timing.
  task automatic runEpisode(input string name, input stim_t s, input exp_t e, input int clearDelay);
    applyStimulus(s, clearDelay == 0);
    tick;
    i_exc_valid    = 1'b0;
    i_mret         = 1'b0;
    i_mip          = '0;
    i_exc_tval     = ~s.exc_tval;
    i_epc          = ~s.epc;
    i_mepc_in      = ~s.mepc_in;
    i_mstatus_mie  = ~s.mstatus_mie;
    i_mstatus_mpie = ~s.mstatus_mpie;
    i_mstatus_mpp  = ~s.mstatus_mpp;
    i_curr_priv    = ~s.curr_priv;
    if (!e.taken) begin
      for (int c = 0; c < 3; c++) begin
        checkOutput({name, "_idle_busy"}, 32'(o_busy), 32'd0);
        checkOutput({name, "_idle_inject"}, 32'(o_inject_csr), 32'd0);
        checkOutput({name, "_idle_insert"}, 32'(o_insert_pc), 32'd0);
        tick;
      end
      return;
    end
    checkOutput({name, "_busy_latch"}, 32'(o_busy), 32'd1);
    checkOutput({name, "_intr_latch"}, 32'(o_intr), 32'(e.intr));
    for (int d = 0; d < clearDelay; d++) begin
      i_exc_valid = 1'b1;
      i_exc_code  = ~s.exc_code;
      i_mret      = 1'b1;
      tick;
      checkOutput({name, "_wait_inject"}, 32'(o_inject_csr), 32'd0);
      checkOutput({name, "_wait_busy"}, 32'(o_busy), 32'd1);
    end
    i_exc_valid  = 1'b0;
    i_mret       = 1'b0;
    i_pipe_clear = 1'b1;
    tick;
    checkOutput({name, "_early_inject"}, 32'(o_inject_csr), 32'd0);
    checkOutput({name, "_early_insert"}, 32'(o_insert_pc), 32'd0);
    tick;
    checkOutput({name, "_inject"}, 32'(o_inject_csr), 32'd1);
    checkOutput({name, "_inject_insert"}, 32'(o_insert_pc), 32'd0);
    checkOutput({name, "_mcause"}, o_next_mcause, e.mcause);
    checkOutput({name, "_mepc"}, o_next_mepc, e.mepc);
    checkOutput({name, "_mtval"}, o_next_mtval, e.mtval);
    checkOutput({name, "_mie_bit"}, 32'(o_next_mie_bit), 32'(e.mie_bit));
    checkOutput({name, "_mpie"}, 32'(o_next_mpie), 32'(e.mpie));
    checkOutput({name, "_mpp"}, 32'(o_next_mpp), 32'(e.mpp));
    checkOutput({name, "_priv"}, 32'(o_next_priv), 32'(e.priv));
    tick;
    checkOutput({name, "_insert"}, 32'(o_insert_pc), 32'd1);
    checkOutput({name, "_priv_pc"}, o_priv_pc, e.pc);
    checkOutput({name, "_insert_inject"}, 32'(o_inject_csr), 32'd0);
    checkOutput({name, "_mcause_hold"}, o_next_mcause, e.mcause);
    checkOutput({name, "_priv_hold"}, 32'(o_next_priv), 32'(e.priv));
    checkOutput({name, "_intr_redirect"}, 32'(o_intr), 32'(e.intr));
    tick;
    checkOutput({name, "_insert_done"}, 32'(o_insert_pc), 32'd0);
    checkOutput({name, "_busy_done"}, 32'(o_busy), 32'd0);
    heldCause = e.mcause;
    heldEpc   = e.mepc;
    heldTval  = e.mtval;
  endtask

  initial begin
    stim_t s;
    exp_t  e;

    // Fields: exc_valid, exc_code, exc_tval, epc, mip, mie, mstatus_mie,
    // mstatus_mpie, mstatus_mpp, curr_priv, mtvec, mepc_in, mret.
    // Expected: taken, intr, mcause, mepc, mtval, mie_bit, mpie, mpp, priv, pc.
    addVec("illegal_instr",
      '{1'b1, 4'd2, 32'h0000_DEAD, 32'h0000_0100, 12'h000, 12'h000, 1'b1, 1'b0, 2'b00, 2'b11, 32'h0000_8000, 32'h0, 1'b0},
      '{1'b1, 1'b0, 32'h0000_0002, 32'h0000_0100, 32'h0000_DEAD, 1'b0, 1'b1, 2'b11, 2'b11, 32'h0000_8000}, 0);
    addVec("mei_over_mti",
      '{1'b0, 4'd0, 32'h0000_1234, 32'h0000_0400, 12'h880, 12'hFFF, 1'b0, 1'b1, 2'b11, 2'b00, 32'h0000_8001, 32'h0, 1'b0},
      '{1'b1, 1'b1, 32'h8000_000B, 32'h0000_0400, 32'h0, 1'b0, 1'b0, 2'b00, 2'b11, MEI_PC}, 0);
    addVec("mret_to_user",
      '{1'b0, 4'd0, 32'h0, 32'h0000_0010, 12'h000, 12'h000, 1'b0, 1'b1, 2'b00, 2'b11, 32'h0000_8000, 32'h0000_0203, 1'b1},
      '{1'b1, 1'b0, 32'h8000_000B, 32'h0000_0400, 32'h0, 1'b1, 1'b1, 2'b00, 2'b00, 32'h0000_0200}, 0);
    addVec("exc_beats_irq",
      '{1'b1, 4'd11, 32'h0, 32'h0000_0500, 12'h808, 12'hFFF, 1'b1, 1'b0, 2'b01, 2'b11, 32'h0000_8000, 32'h0, 1'b0},
      '{1'b1, 1'b0, 32'h0000_000B, 32'h0000_0500, 32'h0, 1'b0, 1'b1, 2'b11, 2'b11, 32'h0000_8000}, 5);
    addVec("mret_over_masked_irq",
      '{1'b0, 4'd0, 32'h0, 32'h0000_0020, 12'h800, 12'h800, 1'b0, 1'b0, 2'b01, 2'b11, 32'h0000_8000, 32'h0000_1000, 1'b1},
      '{1'b1, 1'b0, 32'h0000_000B, 32'h0000_0500, 32'h0, 1'b0, 1'b1, 2'b00, 2'b01, 32'h0000_1000}, 2);
    addVec("ssi_over_sti",
      '{1'b0, 4'd0, 32'h0, 32'h0000_0600, 12'h822, 12'h022, 1'b0, 1'b0, 2'b01, 2'b01, 32'h0000_9001, 32'h0, 1'b0},
      '{1'b1, 1'b1, 32'h8000_0001, 32'h0000_0600, 32'h0, 1'b0, 1'b0, 2'b01, 2'b11, SSI_PC}, 1);
    addVec("reserved_mode_exc",
      '{1'b1, 4'd5, 32'h0000_0044, 32'h0000_0700, 12'h000, 12'h000, 1'b1, 1'b1, 2'b11, 2'b00, 32'h0000_8003, 32'h0, 1'b0},
      '{1'b1, 1'b0, 32'h0000_0005, 32'h0000_0700, 32'h0000_0044, 1'b0, 1'b1, 2'b00, 2'b11, 32'h0000_8000}, 0);
    addVec("masked_irq_idle",
      '{1'b0, 4'd0, 32'h0, 32'h0, 12'h800, 12'h800, 1'b0, 1'b0, 2'b00, 2'b11, 32'h0000_8000, 32'h0, 1'b0},
      '{1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00, 2'b00, 32'h0}, 0);

    i_rst = 1'b1;
    tick;
    tick;
    checkOutput("reset_busy", 32'(o_busy), 32'd0);
    checkOutput("reset_intr", 32'(o_intr), 32'd0);
    checkOutput("reset_inject", 32'(o_inject_csr), 32'd0);
    checkOutput("reset_insert", 32'(o_insert_pc), 32'd0);
    checkOutput("reset_mcause", o_next_mcause, 32'd0);
    checkOutput("reset_mepc", o_next_mepc, 32'd0);
    checkOutput("reset_mtval", o_next_mtval, 32'd0);
    checkOutput("reset_mie_bit", 32'(o_next_mie_bit), 32'd0);
    checkOutput("reset_mpie", 32'(o_next_mpie), 32'd0);
    checkOutput("reset_mpp", 32'(o_next_mpp), 32'd0);
    checkOutput("reset_priv", 32'(o_next_priv), 32'd0);
    checkOutput("reset_priv_pc", o_priv_pc, 32'd0);
    i_rst = 1'b0;
    i_pipe_clear = 1'b1;
    tick;

    for (int i = 0; i < numVecs; i++) begin
      runEpisode(vecs[i].name, vecs[i].s, vecs[i].e, vecs[i].clearDelay);
    end

    for (int n = 0; n < 60; n++) begin
      s = '0;
      s.exc_valid    = ($urandom_range(0, 2) == 0);
      s.exc_code     = 4'($urandom_range(0, 15));
      s.exc_tval     = $urandom();
      s.epc          = $urandom();
      s.mip          = 12'($urandom()) & 12'hAAA;
      s.mie          = 12'($urandom());
      s.mstatus_mie  = 1'($urandom_range(0, 1));
      s.mstatus_mpie = 1'($urandom_range(0, 1));
      s.mstatus_mpp  = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0:       s.curr_priv = 2'b00;
        1:       s.curr_priv = 2'b01;
        default: s.curr_priv = 2'b11;
      endcase
      s.mtvec        = $urandom();
      s.mepc_in      = $urandom();
      s.mret         = 1'($urandom_range(0, 1));
      e = modelEpisode(s, heldCause, heldEpc, heldTval);
      runEpisode("random", s, e, int'($urandom_range(0, 3)));
    end

    // Reset while an exception waits for the pipeline: nothing may escape.
    s = '0;
    s.exc_valid = 1'b1;
    s.exc_code  = 4'd6;
    s.epc       = 32'h0000_0900;
    s.mtvec     = 32'h0000_8000;
    s.curr_priv = 2'b11;
    applyStimulus(s, 1'b0);
    tick;
    checkOutput("rst_wait_busy", 32'(o_busy), 32'd1);
    i_exc_valid = 1'b0;
    i_rst = 1'b1;
    tick;
    checkOutput("rst_wait_busy_cleared", 32'(o_busy), 32'd0);
    checkOutput("rst_wait_intr", 32'(o_intr), 32'd0);
    checkOutput("rst_wait_mcause", o_next_mcause, 32'd0);
    checkOutput("rst_wait_mepc", o_next_mepc, 32'd0);
    checkOutput("rst_wait_priv", 32'(o_next_priv), 32'd0);
    checkOutput("rst_wait_priv_pc", o_priv_pc, 32'd0);
    i_rst = 1'b0;
    i_pipe_clear = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick;
      checkOutput("rst_after_inject", 32'(o_inject_csr), 32'd0);
      checkOutput("rst_after_insert", 32'(o_insert_pc), 32'd0);
      checkOutput("rst_after_busy", 32'(o_busy), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
